imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the byte-addressed, big-endian instruction memory that the fetch unit reads.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them one byte per cycle into internal byte storage.
- Provides the combinational 32-bit fetch read port the fetch unit consumes.
- Asserts cpu_hold so the pipeline is frozen while a program is being loaded.

Parameters:
DEPTH_BYTES, 64, instruction memory size in bytes; power of 2 and at least 8.
ADDR_W, 32, width of ld_base and fetch_addr.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
ld_start  input  1  start-load request; sampled in IDLE only.
ld_base  input  ADDR_W  byte address of the first word; must be word-aligned.
ld_count  input  8  number of words to load.
ld_valid  input  1  ld_data is valid.
ld_data  input  32  instruction word; bits 31:24 go to the lowest byte address.
ld_ready  output  1  block accepts a word this cycle (registered).
fetch_addr  input  ADDR_W  fetch byte address.
fetch_instr  output  32  {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
cpu_hold  output  1  high while a load is in progress.
ld_done  output  1  one-cycle pulse at the end of a load.
ld_err  output  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - ld_ready=0, cpu_hold=0, ld_done=0, ld_err=0.
  - Pointer, remaining count, word register and byte index cleared.
  - Memory contents are not cleared.
- States: IDLE, ACCEPT, WRITE, DONE. All outputs are registered except fetch_instr.
- IDLE, on ld_start=1:
  - ld_base[1:0]!=0: set ld_err, stay in IDLE, cpu_hold stays 0.
  - ld_count==0: clear ld_err, go to DONE; cpu_hold stays 0.
  - Otherwise: clear ld_err, latch ptr=ld_base and rem=ld_count, go to ACCEPT, cpu_hold=1 from the next cycle.
- ld_start outside IDLE is ignored.
- ACCEPT:
  - ld_ready=1.
  - On the edge where ld_valid&&ld_ready: latch ld_data, ld_ready=0 from the next cycle.
  - If ptr+3 < DEPTH_BYTES: go to WRITE with idx=0.
  - Otherwise (out of range): drop the word, set ld_err, ptr+=4, rem-=1, then go to DONE if rem reaches 0, else stay in ACCEPT.
  - ld_valid low: remain in ACCEPT indefinitely with no writes; ld_data is don't-care.
- WRITE:
  - One byte per cycle: mem[ptr+idx] <= word[31-8*idx -: 8], idx=0..3.
  - After idx=3: ptr+=4, rem-=1; go to DONE if rem==0, else to ACCEPT.
  - Minimum cost is 5 cycles per word (1 accept + 4 write).
- DONE (one cycle): ld_done=1, cpu_hold=0, then return to IDLE. ld_err persists until the next accepted ld_start.
- Pointer arithmetic is ADDR_W wide; the out-of-range check compares the full address and never wraps.
- Fetch port:
  - Combinational read with a = fetch_addr mod DEPTH_BYTES; byte addresses a+1..a+3 also wrap modulo DEPTH_BYTES.
  - A read during a write returns the pre-edge byte value.
  - The read is valid in every state.
- Reset mid-load: bytes already written keep their new values and unwritten bytes keep their old values; all outputs return to reset values.

Test Plan:
1. Load 2 words:
   - Stimulus: ld_start with base=0, count=2; words 0x00864827 and 0x08000005, ld_valid held high.
   - Required: ld_ready high 1 cycle after start; cpu_hold high 10 cycles.
   - Required: ld_done pulses exactly once, in the same cycle cpu_hold falls.
   - Required: fetch_addr=0 gives 0x00864827; fetch_addr=4 gives 0x08000005; mem[4]=0x08.
2. Stall the handshake:
   - Stimulus: as scenario 1, but ld_valid low for 3 cycles in ACCEPT.
   - Required: ld_ready stays 1, no memory change, cpu_hold stays 1.
   - Required: load completes 3 cycles later with the same memory result.
3. Misaligned base:
   - Stimulus: base=62, count=1.
   - Required: ld_err=1 next cycle; cpu_hold, ld_ready and ld_done stay 0; memory unchanged.
4. Out-of-range word:
   - Stimulus: base=60, count=2, words 0xAABBCCDD and 0x11223344.
   - Required: bytes 60..63 = AA BB CC DD; the second word is dropped; ld_err=1; ld_done pulses.
   - Required: fetch_addr=62 gives 0xCCDDxxxx, wrapping to bytes 0 and 1.
5. Reset mid-write:
   - Stimulus: drop rst_n after 2 WRITE cycles of word 0x12345678 at base 8.
   - Required: mem[8]=0x12 and mem[9]=0x34; mem[10..11] unchanged; all outputs 0 immediately.
6. Zero-length load:
   - Stimulus: ld_count=0.
   - Required: ld_done pulses 1 cycle after start; cpu_hold never asserts; ld_err cleared.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the byte-addressed, big-endian instruction memory read by the
// fetch unit. Instruction words arrive over a valid/ready handshake and are
// written one byte per cycle (most significant byte at the lowest address).
// The pipeline is held off through cpu_hold while a load is running.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ld_start          start-load request (only looked at in IDLE)
//   ld_base           word-aligned byte address of the first word
//   ld_count          number of words to load
//   ld_valid/ld_data  incoming instruction word and its valid strobe
//   ld_ready          registered ready: a word is taken on valid && ready
//   fetch_addr        fetch byte address (taken modulo DEPTH_BYTES)
//   fetch_instr       combinational {mem[a], mem[a+1], mem[a+2], mem[a+3]}
//   cpu_hold          high while a load is in progress
//   ld_done           one-cycle pulse at the end of a load
//   ld_err            sticky error flag, cleared by the next accepted ld_start
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [7:0]        ld_count,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_instr,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic              ld_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        rem_q, rem_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic              ld_ready_q, ld_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              ld_done_q, ld_done_d;
    logic              ld_err_q, ld_err_d;

    logic [7:0]        mem_q [DEPTH_BYTES];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [7:0]        mem_wdata;

    // The range check is done one bit wider than the pointer so that a base
    // near the top of the address space cannot wrap back into range.
    logic [ADDR_W:0]   last_byte;
    logic              in_range;

    assign last_byte = {1'b0, ptr_q} + (ADDR_W + 1)'(3);
    assign in_range  = last_byte < (ADDR_W + 1)'(DEPTH_BYTES);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal gets its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        word_d     = word_q;
        idx_d      = idx_q;
        ld_ready_d = ld_ready_q;
        cpu_hold_d = cpu_hold_q;
        ld_done_d  = 1'b0;
        ld_err_d   = ld_err_q;

        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    if (ld_base[1:0] != 2'b00) begin
                        ld_err_d = 1'b1;
                    end else if (ld_count == 8'd0) begin
                        ld_err_d  = 1'b0;
                        ld_done_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        ld_err_d   = 1'b0;
                        ptr_d      = ld_base;
                        rem_d      = ld_count;
                        ld_ready_d = 1'b1;
                        cpu_hold_d = 1'b1;
                        state_d    = S_ACCEPT;
                    end
                end
            end

            S_ACCEPT: begin
                if (ld_valid && ld_ready_q) begin
                    word_d = ld_data;
                    if (in_range) begin
                        idx_d      = 2'd0;
                        ld_ready_d = 1'b0;
                        state_d    = S_WRITE;
                    end else begin
                        // Word would land past the end of memory: drop it
                        // but still consume its slot in the stream.
                        ld_err_d = 1'b1;
                        ptr_d    = ptr_q + ADDR_W'(4);
                        rem_d    = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            ld_ready_d = 1'b0;
                            cpu_hold_d = 1'b0;
                            ld_done_d  = 1'b1;
                            state_d    = S_DONE;
                        end
                    end
                end
            end

            S_WRITE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    ptr_d = ptr_q + ADDR_W'(4);
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        cpu_hold_d = 1'b0;
                        ld_done_d  = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        ld_ready_d = 1'b1;
                        state_d    = S_ACCEPT;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of the others.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            ld_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            ld_done_q  <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            ld_ready_q <= ld_ready_d;
            cpu_hold_q <= cpu_hold_d;
            ld_done_q  <= ld_done_d;
            ld_err_q   <= ld_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte storage: one byte per WRITE cycle, big-endian within the word
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = (state_q == S_WRITE);
        mem_waddr = ptr_q[AW-1:0] + AW'(idx_q);
        case (idx_q)
            2'd0:    mem_wdata = word_q[31:24];
            2'd1:    mem_wdata = word_q[23:16];
            2'd2:    mem_wdata = word_q[15:8];
            default: mem_wdata = word_q[7:0];
        endcase
    end

    // NOTE: the storage array has no reset; its contents must survive a
    // reset, and clearing it would cost a reset net on every byte.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Fetch read port: all four byte addresses wrap modulo DEPTH_BYTES.
    // A write landing on the same edge is not visible until after it.
    // ------------------------------------------------------------------
    logic [AW-1:0] fa0, fa1, fa2, fa3;
    logic          fetch_addr_unused;

    assign fa0 = fetch_addr[AW-1:0];
    assign fa1 = fa0 + AW'(1);
    assign fa2 = fa0 + AW'(2);
    assign fa3 = fa0 + AW'(3);
    assign fetch_addr_unused = ^fetch_addr[ADDR_W-1:AW];

    assign fetch_instr = {mem_q[fa0], mem_q[fa1], mem_q[fa2], mem_q[fa3]};

    assign ld_ready = ld_ready_q;
    assign cpu_hold = cpu_hold_q;
    assign ld_done  = ld_done_q;
    assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Memory is first filled with a known pattern
// (byte i = 0x80 + i) so later "unchanged" checks compare against real data.
// All expected values below are hand-computed from the block's behaviour.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        ld_start;
    logic [31:0] ld_base;
    logic [7:0]  ld_count;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        cpu_hold;
    logic        ld_done;
    logic        ld_err;

    imem_loader #(
        .DEPTH_BYTES(64),
        .ADDR_W     (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_count   (ld_count),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .fetch_addr (fetch_addr),
        .fetch_instr(fetch_instr),
        .cpu_hold   (cpu_hold),
        .ld_done    (ld_done),
        .ld_err     (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass;
    int          n_total;

    logic [31:0] ld_words [16];

    // Results of the most recent run_load.
    logic        r_first_ready;
    int          r_hold_cycles;
    int          r_done_pulses;
    int          r_done_idx;
    logic        r_hold_at_done;
    logic        r_stall_ok;

    logic [31:0] rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
        fetch_addr = addr;
        #1;
        data = fetch_instr;
    endtask

    // Runs one load using ld_words[0..count-1]. ld_valid is held high (except
    // for the first 'stall' cycles in ACCEPT); observation i is taken just
    // after edge i, edge 0 being the one that samples ld_start.
    task automatic run_load(input logic [31:0] base, input logic [7:0] count, input int stall);
        int nxt;
        int stall_left;
        r_first_ready  = 1'b0;
        r_hold_cycles  = 0;
        r_done_pulses  = 0;
        r_done_idx     = -1;
        r_hold_at_done = 1'b1;
        r_stall_ok     = 1'b1;
        nxt            = 0;
        stall_left     = stall;

        ld_base  = base;
        ld_count = count;
        ld_start = 1'b1;
        ld_valid = 1'b0;
        step();
        ld_start      = 1'b0;
        r_first_ready = ld_ready;

        for (int i = 0; i < 300; i++) begin
            if (cpu_hold === 1'b1) r_hold_cycles++;
            if (ld_done === 1'b1) begin
                r_done_pulses++;
                if (r_done_idx < 0) begin
                    r_done_idx     = i;
                    r_hold_at_done = cpu_hold;
                end
            end else if (r_done_idx >= 0) begin
                break;
            end

            if (stall_left > 0) begin
                if (!(ld_ready === 1'b1 && cpu_hold === 1'b1)) r_stall_ok = 1'b0;
                ld_valid = 1'b0;
                stall_left--;
            end else if (nxt < int'(count)) begin
                ld_valid = 1'b1;
                ld_data  = ld_words[nxt];
                if (ld_ready === 1'b1) nxt++;
            end else begin
                ld_valid = 1'b0;
            end
            step();
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        ld_start   = 1'b0;
        ld_base    = '0;
        ld_count   = '0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        fetch_addr = '0;

        // ---------------- reset state ----------------
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd0);
        check("rst_done",  32'(ld_done),  32'd0);
        check("rst_err",   32'(ld_err),   32'd0);
        #9 rst_n = 1'b1;
        step();

        // ---------------- prefill: 16 words, byte i = 0x80 + i ----------------
        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            b = 8'h80 + 8'(4 * k);
            ld_words[k] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
        end
        run_load(32'd0, 8'd16, 0);
        check("pre_hold_cycles", 32'(r_hold_cycles), 32'd80);
        check("pre_done_idx",    32'(r_done_idx),    32'd80);
        read_word(32'd8, rd);
        check("pre_fetch8", rd, 32'h88898A8B);
        read_word(32'd62, rd);
        check("pre_fetch62_wrap", rd, 32'hBEBF8081);

        // ---------------- 1: load two words ----------------
        ld_words[0] = 32'h00864827;
        ld_words[1] = 32'h08000005;
        run_load(32'd0, 8'd2, 0);
        check("t1_first_ready",  32'(r_first_ready),  32'd1);
        check("t1_hold_cycles",  32'(r_hold_cycles),  32'd10);
        check("t1_done_pulses",  32'(r_done_pulses),  32'd1);
        check("t1_done_idx",     32'(r_done_idx),     32'd10);
        check("t1_hold_at_done", 32'(r_hold_at_done), 32'd0);
        check("t1_err",          32'(ld_err),         32'd0);
        read_word(32'd0, rd);
        check("t1_fetch0", rd, 32'h00864827);
        read_word(32'd4, rd);
        check("t1_fetch4", rd, 32'h08000005);
        check("t1_mem4",   32'(rd[31:24]), 32'h08);
        read_word(32'd8, rd);
        check("t1_fetch8_untouched", rd, 32'h88898A8B);

        // ---------------- 2: stalled handshake ----------------
        run_load(32'd0, 8'd2, 3);
        check("t2_stall_ready_hold", 32'(r_stall_ok),    32'd1);
        check("t2_hold_cycles",      32'(r_hold_cycles), 32'd13);
        check("t2_done_pulses",      32'(r_done_pulses), 32'd1);
        check("t2_done_idx",         32'(r_done_idx),    32'd13);
        read_word(32'd0, rd);
        check("t2_fetch0", rd, 32'h00864827);
        read_word(32'd4, rd);
        check("t2_fetch4", rd, 32'h08000005);

        // ---------------- 3: misaligned base ----------------
        ld_base  = 32'd62;
        ld_count = 8'd1;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("t3_err",   32'(ld_err),   32'd1);
        check("t3_hold",  32'(cpu_hold), 32'd0);
        check("t3_ready", 32'(ld_ready), 32'd0);
        check("t3_done",  32'(ld_done),  32'd0);
        step();
        step();
        check("t3_hold_later",  32'(cpu_hold), 32'd0);
        check("t3_ready_later", 32'(ld_ready), 32'd0);
        check("t3_done_later",  32'(ld_done),  32'd0);
        read_word(32'd60, rd);
        check("t3_fetch60", rd, 32'hBCBDBEBF);

        // ---------------- 4: out-of-range second word ----------------
        ld_words[0] = 32'hAABBCCDD;
        ld_words[1] = 32'h11223344;
        run_load(32'd60, 8'd2, 0);
        check("t4_done_pulses", 32'(r_done_pulses), 32'd1);
        check("t4_done_idx",    32'(r_done_idx),    32'd6);
        check("t4_hold_cycles", 32'(r_hold_cycles), 32'd6);
        check("t4_err",         32'(ld_err),        32'd1);
        read_word(32'd60, rd);
        check("t4_fetch60", rd, 32'hAABBCCDD);
        read_word(32'd62, rd);
        check("t4_fetch62_wrap", rd, 32'hCCDD0086);
        read_word(32'd0, rd);
        check("t4_fetch0_no_wrap_write", rd, 32'h00864827);
        step();
        check("t4_err_sticky", 32'(ld_err), 32'd1);

        // ---------------- 5: reset mid-write ----------------
        ld_base  = 32'd8;
        ld_count = 8'd1;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("t5_err_cleared", 32'(ld_err),   32'd0);
        check("t5_ready",       32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_data  = 32'h12345678;
        step();
        ld_valid = 1'b0;
        step();
        step();
        check("t5_hold_before_rst", 32'(cpu_hold), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(ld_ready), 32'd0);
        check("t5_rst_hold",  32'(cpu_hold), 32'd0);
        check("t5_rst_done",  32'(ld_done),  32'd0);
        check("t5_rst_err",   32'(ld_err),   32'd0);
        #1 rst_n = 1'b1;
        step();
        step();
        check("t5_hold_after", 32'(cpu_hold), 32'd0);
        read_word(32'd8, rd);
        check("t5_fetch8", rd, 32'h12348A8B);

        // ---------------- 6: zero-length load ----------------
        ld_base  = 32'd2;
        ld_count = 8'd1;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("t6_err_set", 32'(ld_err), 32'd1);
        step();
        run_load(32'd0, 8'd0, 0);
        check("t6_done_idx",    32'(r_done_idx),    32'd0);
        check("t6_done_pulses", 32'(r_done_pulses), 32'd1);
        check("t6_hold_cycles", 32'(r_hold_cycles), 32'd0);
        check("t6_err_cleared", 32'(ld_err),        32'd0);
        read_word(32'd0, rd);
        check("t6_fetch0", rd, 32'h00864827);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
